// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, port field, length field, payload
// (MSB of the valid payload first), stop bit; one bit per enabled clock.
module serial_frame_tx #(
  parameter int PORT_W = 2,
  parameter int LEN_W  = 5,
  parameter int DATA_W = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              start,
  input  logic [PORT_W-1:0] port_in,
  input  logic [LEN_W-1:0]  len_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              ser_out,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  bits_left
);

  localparam int HDR_W = PORT_W + LEN_W;
  localparam int CNT_W = ($clog2(HDR_W) > 3) ? $clog2(HDR_W) : 3;

  typedef enum logic [2:0] {IDLE, START, PORT, LEN, DATA, STOP} state_t;

  state_t            state;
  logic [HDR_W-1:0]  hdr_r;
  logic [DATA_W-1:0] dat_r;
  logic [CNT_W-1:0]  cnt;

  // Header and payload are both shifted out from their MSB. The payload is
  // left-aligned at acceptance so bit len-1 leads and unused bits never reach
  // the line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ser_out   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      bits_left <= '0;
      hdr_r     <= '0;
      dat_r     <= '0;
      cnt       <= '0;
    end else begin
      done <= 1'b0;
      if (clk_en) begin
        case (state)
          IDLE: begin
            ser_out <= 1'b1;
            if (start) begin
              hdr_r     <= {port_in, len_in};
              dat_r     <= data_in << (DATA_W - int'(len_in));
              bits_left <= len_in;
              busy      <= 1'b1;
              ser_out   <= 1'b0;
              state     <= START;
            end
          end
          START: begin
            ser_out <= hdr_r[HDR_W-1];
            hdr_r   <= hdr_r << 1;
            cnt     <= CNT_W'(PORT_W - 1);
            state   <= PORT;
          end
          PORT: begin
            ser_out <= hdr_r[HDR_W-1];
            hdr_r   <= hdr_r << 1;
            if (cnt == '0) begin
              cnt   <= CNT_W'(LEN_W - 1);
              state <= LEN;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          LEN: begin
            if (cnt != '0) begin
              ser_out <= hdr_r[HDR_W-1];
              hdr_r   <= hdr_r << 1;
              cnt     <= cnt - 1'b1;
            end else if (bits_left != '0) begin
              ser_out <= dat_r[DATA_W-1];
              dat_r   <= dat_r << 1;
              cnt     <= '0;
              state   <= DATA;
            end else begin
              ser_out <= 1'b1;
              cnt     <= '0;
              state   <= STOP;
            end
          end
          DATA: begin
            // bits_left counts the payload bit currently on the line
            bits_left <= bits_left - 1'b1;
            if (bits_left == LEN_W'(1)) begin
              ser_out <= 1'b1;
              cnt     <= '0;
              state   <= STOP;
            end else begin
              ser_out <= dat_r[DATA_W-1];
              dat_r   <= dat_r << 1;
            end
          end
          STOP: begin
            ser_out <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            cnt     <= '0;
            state   <= IDLE;
          end
          default: begin
            ser_out <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Randomized bench for serial_frame_tx: each frame is predicted as a bit list
// built from the field rules and compared bit by bit on enabled cycles.
module tb_serial_frame_tx;
  localparam int PORT_W = 2;
  localparam int LEN_W  = 5;
  localparam int DATA_W = 31;
  localparam int HDR_N  = 1 + PORT_W + LEN_W;

  logic              clk = 1'b0;
  logic              rst, clk_en, start;
  logic [PORT_W-1:0] port_in;
  logic [LEN_W-1:0]  len_in;
  logic [DATA_W-1:0] data_in;
  logic              ser_out, busy, done;
  logic [LEN_W-1:0]  bits_left;

  int n_chk = 0;
  int n_err = 0;
  logic [63:0] obs;

  serial_frame_tx #(.PORT_W(PORT_W), .LEN_W(LEN_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .start(start),
    .port_in(port_in), .len_in(len_in), .data_in(data_in),
    .ser_out(ser_out), .busy(busy), .done(done), .bits_left(bits_left)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input bit en);
    @(negedge clk);
    clk_en = en;
    @(posedge clk);
    #1;
  endtask

  task automatic junk_start();
    if ($urandom_range(3) == 0) begin
      start   = 1'b1;
      port_in = PORT_W'($urandom);
      len_in  = LEN_W'($urandom);
      data_in = DATA_W'($urandom);
    end else begin
      start = 1'b0;
    end
  endtask

  // rst_k >= 0: reset instead of the enabled edge that would put bit rst_k out
  task automatic run_frame(input logic [PORT_W-1:0] p, input logic [LEN_W-1:0] l,
                           input logic [DATA_W-1:0] d, input int per,
                           input bit chain, input int rst_k);
    bit q[$];
    int n, exp_bl;
    q.push_back(1'b0);
    for (int i = PORT_W-1; i >= 0; i--) q.push_back(p[i]);
    for (int i = LEN_W-1; i >= 0; i--) q.push_back(l[i]);
    for (int i = int'(l)-1; i >= 0; i--) q.push_back(d[i]);
    q.push_back(1'b1);
    n = q.size();
    obs = '0;
    for (int k = 0; k <= n; k++) begin
      if (k > 0) begin
        for (int w = 1; w < per; w++) begin
          junk_start();
          tick(1'b0);
          chk("hold_ser", ser_out, q[k-1]);
          chk("hold_done", done, 0);
          chk("hold_busy", busy, 1);
        end
      end
      if (k == rst_k) begin
        rst = 1'b1; start = 1'b0;
        tick(1'($urandom_range(1)));
        rst = 1'b0;
        chk("rst_ser", ser_out, 1);
        chk("rst_busy", busy, 0);
        chk("rst_bits_left", bits_left, 0);
        chk("rst_done", done, 0);
        tick(1'b1);
        chk("rst_after_done", done, 0);
        chk("rst_after_ser", ser_out, 1);
        chk("rst_after_busy", busy, 0);
        return;
      end
      if (k == 0) begin
        start = 1'b1; port_in = p; len_in = l; data_in = d;
      end else begin
        junk_start();
        if (k == n && chain) start = 1'b1;
      end
      tick(1'b1);
      if (k < n) begin
        if (k < HDR_N) exp_bl = int'(l);
        else if (k < HDR_N + int'(l)) exp_bl = int'(l) - (k - HDR_N);
        else exp_bl = 0;
        obs = {obs[62:0], ser_out};
        chk("ser", ser_out, q[k]);
        chk("busy", busy, 1);
        chk("bits_left", bits_left, 64'(exp_bl));
        chk("done_early", done, 0);
      end else begin
        chk("done_pulse", done, 1);
        chk("end_busy", busy, 0);
        chk("end_ser", ser_out, 1);
        chk("end_bits_left", bits_left, 0);
      end
    end
    if (!chain) begin
      start = 1'b0;
      tick(1'b0);
      chk("done_clear", done, 0);
      chk("idle_ser", ser_out, 1);
    end
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b0; start = 1'b0;
    port_in = '0; len_in = '0; data_in = '0;
    tick(1'b1);
    rst = 1'b0;
    chk("reset_ser", ser_out, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_bits_left", bits_left, 0);
    for (int i = 0; i < 10; i++) begin
      tick(1'($urandom_range(1)));
      chk("idle_ser", ser_out, 1);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
    end

    run_frame(2'b10, 5'd3, 31'b101, 1, 1'b0, -1);
    chk("seq_example", obs, 64'b010000111011);
    run_frame(2'b11, 5'd0, DATA_W'($urandom), 1, 1'b0, -1);
    chk("seq_len0", obs, 64'b011000001);
    run_frame(PORT_W'($urandom), 5'd31, {DATA_W{1'b1}}, 4, 1'b0, -1);
    run_frame(2'b01, 5'd5, DATA_W'($urandom), 1, 1'b1, -1);
    run_frame(2'b10, 5'd2, DATA_W'($urandom), 1, 1'b0, -1);

    for (int i = 0; i < 25; i++)
      run_frame(PORT_W'($urandom), LEN_W'($urandom), DATA_W'($urandom),
                $urandom_range(1, 3), 1'($urandom_range(1)), -1);
    run_frame(2'b00, 5'd1, DATA_W'($urandom), 2, 1'b0, -1);

    run_frame(2'b10, 5'd20, DATA_W'($urandom), 1, 1'b0, 22);
    run_frame(2'b01, 5'd7, DATA_W'($urandom), 1, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
